ahb_apb4_bridge_mux: RTL and testbench
======================================

Name: ahb_apb4_bridge_mux

Overview:
- AHB-lite slave to multi-slave APB4 master bridge. It decodes NSLV APB peripherals from HADDR, generates PSTRB and PPROT, and maps PSLVERR, decode misses and PREADY timeouts to a two-cycle AHB ERROR response.
- Sits between the AHB-lite interconnect and the peripheral subsystem.
- Supports PCLK equal to HCLK, or a slower PCLK qualified by PCLKEN.

Parameters:
- ADDR_W, 32: HADDR/PADDR width.
- NSLV, 4: number of APB slaves, 1..16.
- SEL_LSB, 12: LSB of the slave-index field. Index = HADDR[SEL_LSB +: clog2(NSLV)], forced to 0 when NSLV=1.
- SLOW_PCLK, 1: 1 = PCLK driven from PCLKEN; 0 = PCLK = HCLK and PCLKEN must be tied to 1.
- TIMEOUT, 0: PCLKEN-qualified ACCESS cycles allowed before abort. 0 disables the timeout.

Ports:
- HCLK  in  1  AHB clock
- HRESETn  in  1  async active-low reset
- HSEL  in  1  bridge select
- HADDR  in  ADDR_W  address
- HTRANS  in  2  transfer type
- HWRITE  in  1  write
- HSIZE  in  3  size
- HPROT  in  4  protection
- HWDATA  in  32  write data
- HREADY  in  1  bus ready
- HREADYOUT  out  1  slave ready
- HRESP  out  1  error response
- HRDATA  out  32  read data, registered
- PCLK  out  1  APB clock
- PRESETn  out  1  = HRESETn
- PCLKEN  in  1  APB edge qualifier
- PADDR  out  ADDR_W  APB address
- PSEL  out  NSLV  one-hot select
- PENABLE  out  1  access phase
- PWRITE  out  1  write
- PWDATA  out  32  write data, registered
- PSTRB  out  4  byte strobes
- PPROT  out  3  protection
- PRDATA  in  32*NSLV  slave i uses bits [32i+31:32i]
- PREADY  in  NSLV  per-slave ready
- PSLVERR  in  NSLV  per-slave error

Behaviour:
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, PSTRB=0, PPROT=0, state=IDLE, timeout counter=0.
- HRESETn asserted mid-transfer aborts immediately. No APB signal is held.
- Accept = HSEL & HREADY & HTRANS[1] & HREADYOUT. IDLE and BUSY transfers get a zero-wait OKAY.
- On accept, register: ADDR, WRITE, index, hit (index < NSLV), and PSTRB.
  - PSTRB for writes: byte = 1<<A[1:0]; half = 4'b0011<<(2*A[1]); word = 4'b1111.
  - PSTRB for reads = 0.
- On accept, register PPROT = {~HPROT[0], 1'b0, HPROT[1]}.
- PWDATA captures HWDATA on the first HCLK edge after accept.
- States:
  - IDLE: accept & !hit -> ERR1. accept & hit & PCLKEN -> SETUP. accept & hit & !PCLKEN -> WAIT.
  - WAIT: PCLKEN -> SETUP.
  - SETUP: PSEL[index]=1, PENABLE=0. PCLKEN -> ACCESS.
  - ACCESS: PSEL[index]=1, PENABLE=1. Slave signals are sampled only when PCLKEN=1.
    - PREADY[index] & !PSLVERR[index]: capture PRDATA slice into HRDATA, go to IDLE, HREADYOUT<=1.
    - PREADY[index] & PSLVERR[index]: go to ERR1.
    - Timeout: counter == TIMEOUT-1 with PREADY low -> drop PSEL/PENABLE, go to ERR1.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1 -> IDLE.
- ERR2 never accepts a new transfer. A transfer presented during ERR2 is re-presented by the master.
- HREADYOUT is registered and is 0 from the cycle after accept until completion. No new address is accepted during a transfer.
- PSEL and PENABLE drop on the completion edge. PADDR, PWRITE, PSTRB and PPROT hold their last value.
- Latency with PCLKEN=1 and PREADY=1: accept at T, SETUP at T+1, ACCESS at T+2, HREADYOUT=1 with HRDATA valid at T+3. That is 2 wait states.
- Next transfer accepted at T+3 is back-to-back legal.
- Timeout counter clears on SETUP entry and counts only on PCLKEN cycles in ACCESS.
- PSEL is never multi-hot. PENABLE is never high without PSEL.
- A PSLVERR on a non-selected slave is ignored.

Test Plan:
- NSLV=4, SEL_LSB=12, PCLKEN=1: read 0x2004, slave2 PRDATA=0xA5A5_1234 with PREADY=1 -> PSEL=4'b0100, PADDR=0x2004, PENABLE at T+2, HRDATA=0xA5A5_1234 with HREADYOUT=1 at T+3, HRESP=0.
- Byte write to 0x1003, data 0xDD00_0000, HPROT=4'b0011 -> PSTRB=4'b1000, PWRITE=1, PWDATA=0xDD00_0000, PPROT=3'b001.
- Half-word write to 0x1002 -> PSTRB=4'b1100.
- PCLKEN pulsed every 3rd HCLK: read slave0 with PREADY low for 2 PCLKEN cycles -> SETUP/ACCESS transitions only on PCLKEN edges, PSEL held throughout, correct data returned.
- Write to slave1 with PSLVERR=1 at PREADY -> HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1, then IDLE.
- Write to slave1 with PSLVERR=1 while slave3 PSLVERR=1 -> slave3 error ignored.
- With NSLV=3, access index 3 -> no PSEL asserted, ERROR response.
- TIMEOUT=8, PREADY stuck low -> PSEL drops after 8 ACCESS PCLKEN cycles, ERROR response.
- HRESETn asserted during ACCESS -> PSEL=0, PENABLE=0, HREADYOUT=1 asynchronously.
- After reset release, a new read completes normally.

Source files
------------

// File: rtl/ahb_apb4_bridge_mux.sv
`default_nettype none
// =====================================================================
// Module   : ahb_apb4_bridge_mux
// Function : AHB-lite slave to NSLV-way APB4 master bridge with decode,
//            PSTRB/PPROT generation and ERROR mapping of faults.
// Revision : 1.0  initial release
// =====================================================================
module ahb_apb4_bridge_mux #(
   parameter int ADDR_W    = 32,
   parameter int NSLV      = 4,
   parameter int SEL_LSB   = 12,
   parameter int SLOW_PCLK = 1,
   parameter int TIMEOUT   = 0
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic                 HSEL,
   input  logic [ADDR_W-1:0]    HADDR,
   input  logic [1:0]           HTRANS,
   input  logic                 HWRITE,
   input  logic [2:0]           HSIZE,
   input  logic [3:0]           HPROT,
   input  logic [31:0]          HWDATA,
   input  logic                 HREADY,
   output logic                 HREADYOUT,
   output logic                 HRESP,
   output logic [31:0]          HRDATA,
   output logic                 PCLK,
   output logic                 PRESETn,
   input  logic                 PCLKEN,
   output logic [ADDR_W-1:0]    PADDR,
   output logic [NSLV-1:0]      PSEL,
   output logic                 PENABLE,
   output logic                 PWRITE,
   output logic [31:0]          PWDATA,
   output logic [3:0]           PSTRB,
   output logic [2:0]           PPROT,
   input  logic [32*NSLV-1:0]   PRDATA,
   input  logic [NSLV-1:0]      PREADY,
   input  logic [NSLV-1:0]      PSLVERR
);

   localparam int               IDX_W   = (NSLV > 1) ? $clog2(NSLV) : 1;
   localparam int               TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [IDX_W:0]   NSLV_C  = (IDX_W + 1)'(NSLV);
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WAIT   = 3'd1,
      ST_SETUP  = 3'd2,
      ST_ACCESS = 3'd3,
      ST_ERR1   = 3'd4,
      ST_ERR2   = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic                hreadyout_q, hreadyout_d;
   logic                hresp_q, hresp_d;
   logic [31:0]         hrdata_q, hrdata_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic [NSLV-1:0]     psel_q, psel_d;
   logic                penable_q, penable_d;
   logic                pwrite_q, pwrite_d;
   logic [31:0]         pwdata_q, pwdata_d;
   logic [3:0]          pstrb_q, pstrb_d;
   logic [2:0]          pprot_q, pprot_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [TO_W-1:0]     tcnt_q, tcnt_d;
   logic                wdata_pend_q, wdata_pend_d;

   logic [IDX_W-1:0]    w_haddr_idx;
   logic                w_hit;
   logic                w_accept;
   logic                w_pready;
   logic                w_pslverr;
   logic [31:0]         w_prdata;
   logic [3:0]          w_strb;
   logic                w_unused;

   generate
      if (NSLV == 1) begin : g_idx_single
         assign w_haddr_idx = '0;
      end else begin : g_idx_multi
         assign w_haddr_idx = HADDR[SEL_LSB +: IDX_W];
      end
   endgenerate

   generate
      if (SLOW_PCLK != 0) begin : g_pclk_slow
         assign PCLK = PCLKEN;
      end else begin : g_pclk_fast
         assign PCLK = HCLK;
      end
   endgenerate

   assign PRESETn   = HRESETn;
   assign w_hit     = ({1'b0, w_haddr_idx} < NSLV_C);
   // ERR2 shows HREADYOUT=1 but must not take the re-presented transfer.
   assign w_accept  = HSEL & HREADY & HTRANS[1] & hreadyout_q & (state_q == ST_IDLE);
   assign w_pready  = PREADY[idx_q];
   assign w_pslverr = PSLVERR[idx_q];
   assign w_prdata  = PRDATA[{idx_q, 5'b00000} +: 32];
   assign w_unused  = ^{HTRANS[0], HPROT[3:2]};

   always_comb begin
      w_strb = 4'b0000;
      if (HWRITE) begin
         case (HSIZE)
            3'b000:  w_strb = 4'b0001 << HADDR[1:0];
            3'b001:  w_strb = 4'b0011 << {HADDR[1], 1'b0};
            default: w_strb = 4'b1111;
         endcase
      end
   end

   always_comb begin
      state_d      = state_q;
      hreadyout_d  = hreadyout_q;
      hresp_d      = hresp_q;
      hrdata_d     = hrdata_q;
      paddr_d      = paddr_q;
      psel_d       = psel_q;
      penable_d    = penable_q;
      pwrite_d     = pwrite_q;
      pwdata_d     = pwdata_q;
      pstrb_d      = pstrb_q;
      pprot_d      = pprot_q;
      idx_d        = idx_q;
      tcnt_d       = tcnt_q;
      wdata_pend_d = 1'b0;

      // AHB write data arrives one cycle after the address phase.
      if (wdata_pend_q) begin
         pwdata_d = HWDATA;
      end

      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               paddr_d      = HADDR;
               pwrite_d     = HWRITE;
               idx_d        = w_haddr_idx;
               pstrb_d      = w_strb;
               pprot_d      = {~HPROT[0], 1'b0, HPROT[1]};
               wdata_pend_d = 1'b1;
               hreadyout_d  = 1'b0;
               if (!w_hit) begin
                  state_d = ST_ERR1;
                  hresp_d = 1'b1;
               end else if (PCLKEN) begin
                  state_d = ST_SETUP;
                  psel_d  = NSLV'(1) << w_haddr_idx;
                  tcnt_d  = '0;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (PCLKEN) begin
               state_d = ST_SETUP;
               psel_d  = NSLV'(1) << idx_q;
               tcnt_d  = '0;
            end
         end
         ST_SETUP: begin
            if (PCLKEN) begin
               state_d   = ST_ACCESS;
               penable_d = 1'b1;
            end
         end
         ST_ACCESS: begin
            if (PCLKEN) begin
               if (w_pready) begin
                  psel_d    = '0;
                  penable_d = 1'b0;
                  if (w_pslverr) begin
                     state_d = ST_ERR1;
                     hresp_d = 1'b1;
                  end else begin
                     state_d     = ST_IDLE;
                     hreadyout_d = 1'b1;
                     hrdata_d    = w_prdata;
                  end
               end else if ((TIMEOUT != 0) && (tcnt_q == TO_LAST)) begin
                  psel_d    = '0;
                  penable_d = 1'b0;
                  state_d   = ST_ERR1;
                  hresp_d   = 1'b1;
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
         end
         ST_ERR1: begin
            state_d     = ST_ERR2;
            hreadyout_d = 1'b1;
            hresp_d     = 1'b1;
         end
         ST_ERR2: begin
            state_d     = ST_IDLE;
            hreadyout_d = 1'b1;
            hresp_d     = 1'b0;
         end
         default: begin
            state_d     = ST_IDLE;
            hreadyout_d = 1'b1;
            hresp_d     = 1'b0;
            psel_d      = '0;
            penable_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q      <= ST_IDLE;
         hreadyout_q  <= 1'b1;
         hresp_q      <= 1'b0;
         hrdata_q     <= '0;
         paddr_q      <= '0;
         psel_q       <= '0;
         penable_q    <= 1'b0;
         pwrite_q     <= 1'b0;
         pwdata_q     <= '0;
         pstrb_q      <= '0;
         pprot_q      <= '0;
         idx_q        <= '0;
         tcnt_q       <= '0;
         wdata_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         hreadyout_q  <= hreadyout_d;
         hresp_q      <= hresp_d;
         hrdata_q     <= hrdata_d;
         paddr_q      <= paddr_d;
         psel_q       <= psel_d;
         penable_q    <= penable_d;
         pwrite_q     <= pwrite_d;
         pwdata_q     <= pwdata_d;
         pstrb_q      <= pstrb_d;
         pprot_q      <= pprot_d;
         idx_q        <= idx_d;
         tcnt_q       <= tcnt_d;
         wdata_pend_q <= wdata_pend_d;
      end
   end

   assign HREADYOUT = hreadyout_q;
   assign HRESP     = hresp_q;
   assign HRDATA    = hrdata_q;
   assign PADDR     = paddr_q;
   assign PSEL      = psel_q;
   assign PENABLE   = penable_q;
   assign PWRITE    = pwrite_q;
   assign PWDATA    = pwdata_q;
   assign PSTRB     = pstrb_q;
   assign PPROT     = pprot_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_apb4_bridge_mux.sv
`default_nettype none
// =====================================================================
// Module   : tb_ahb_apb4_bridge_mux
// Function : Self-checking bench for ahb_apb4_bridge_mux.
// Revision : 1.0  initial release
// =====================================================================
module tb_ahb_apb4_bridge_mux;

   localparam int TO = 8;

   logic          HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   logic          HRESETn, HSEL, HSEL3, HWRITE, HREADY, PCLKEN;
   logic [31:0]   HADDR, HWDATA;
   logic [1:0]    HTRANS;
   logic [2:0]    HSIZE;
   logic [3:0]    HPROT;
   logic [127:0]  PRDATA;
   logic [3:0]    PREADY, PSLVERR;

   logic          HREADYOUT, HRESP, PCLK, PRESETn, PENABLE, PWRITE;
   logic [31:0]   HRDATA, PADDR, PWDATA;
   logic [3:0]    PSEL, PSTRB;
   logic [2:0]    PPROT;

   logic          h3_readyout, h3_resp, p3_clk, p3_resetn, p3_enable, p3_write;
   logic [31:0]   h3_rdata, p3_addr, p3_wdata;
   logic [2:0]    p3_sel, p3_prot;
   logic [3:0]    p3_strb;

   ahb_apb4_bridge_mux #(.ADDR_W(32), .NSLV(4), .SEL_LSB(12), .SLOW_PCLK(1), .TIMEOUT(TO)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HPROT(HPROT), .HWDATA(HWDATA), .HREADY(HREADY),
      .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .PCLK(PCLK), .PRESETn(PRESETn),
      .PCLKEN(PCLKEN), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY),
      .PSLVERR(PSLVERR)
   );

   ahb_apb4_bridge_mux #(.ADDR_W(32), .NSLV(3), .SEL_LSB(12), .SLOW_PCLK(1), .TIMEOUT(0)) dut3 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL3), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HPROT(HPROT), .HWDATA(HWDATA), .HREADY(HREADY),
      .HREADYOUT(h3_readyout), .HRESP(h3_resp), .HRDATA(h3_rdata), .PCLK(p3_clk),
      .PRESETn(p3_resetn), .PCLKEN(PCLKEN), .PADDR(p3_addr), .PSEL(p3_sel),
      .PENABLE(p3_enable), .PWRITE(p3_write), .PWDATA(p3_wdata), .PSTRB(p3_strb),
      .PPROT(p3_prot), .PRDATA(PRDATA[95:0]), .PREADY(PREADY[2:0]), .PSLVERR(PSLVERR[2:0])
   );

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   int   div   = 1;
   logic last_pen;
   bit   noise_err3 = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // PCLKEN follows a fixed 1-in-div pattern over the global cycle count.
   function automatic int pen(input int n);
      return ((n % div) == 0) ? 1 : 0;
   endfunction

   task automatic tick();
      PCLKEN   = ((cyc % div) == 0);
      last_pen = PCLKEN;
      @(posedge HCLK);
      #1;
      cyc++;
   endtask

   // Slave k is ready once ACCESS has seen w PCLKEN cycles; others are noise.
   task automatic drive_slaves(input int tgt, input int pe, input int w, input bit err);
      for (int i = 0; i < 4; i++) begin
         PREADY[i]  = 1'($urandom % 2);
         PSLVERR[i] = 1'($urandom % 2);
      end
      if (noise_err3 && tgt != 3) begin
         PREADY[3]  = 1'b1;
         PSLVERR[3] = 1'b1;
      end
      PREADY[tgt]  = (pe >= 2 + w);
      PSLVERR[tgt] = err;
   endtask

   task automatic xfer(input int tgt, input bit wr, input logic [2:0] sz, input logic [31:0] addr,
                       input logic [3:0] prot, input logic [31:0] wdata, input logic [31:0] rdv,
                       input int w, input bit err);
      logic [3:0] oh, exp_strb;
      int         done, k, c, cyc0, pe, low, bad;
      bit         seen, err_exp, last_resp;
      oh      = 4'b0001 << tgt;
      err_exp = err || (w >= TO);
      done    = 3 + ((w >= TO) ? TO - 1 : w);
      if (!wr)          exp_strb = 4'b0000;
      else if (sz == 0) exp_strb = 4'b0001 << addr[1:0];
      else if (sz == 1) exp_strb = addr[1] ? 4'b1100 : 4'b0011;
      else              exp_strb = 4'b1111;
      for (int i = 0; i < 4; i++) PRDATA[i*32 +: 32] = $urandom;
      PRDATA[tgt*32 +: 32] = rdv;
      // Completion lands on the edge that brings the PCLKEN count to 'done'.
      cyc0 = cyc;
      k    = 0;
      c    = pen(cyc0);
      while (c < done) begin
         k++;
         c += pen(cyc0 + k);
      end
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HSIZE = sz; HPROT = prot;
      drive_slaves(tgt, 0, w, err);
      tick();
      pe = int'(last_pen);
      HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata; HADDR = $urandom; HWRITE = 1'($urandom % 2);
      low = 0; bad = 0; seen = 1'b0; last_resp = 1'b0;
      while (HREADYOUT !== 1'b1 && low < 200) begin
         low++;
         if (PSEL !== 4'b0000) begin
            seen = 1'b1;
            if (PSEL !== oh) bad++;
         end
         if (PENABLE === 1'b1 && PSEL === 4'b0000) bad++;
         last_resp = HRESP;
         drive_slaves(tgt, pe, w, err);
         tick();
         pe += int'(last_pen);
      end
      chk("wait_states", 64'(low), 64'(k + (err_exp ? 1 : 0)));
      chk("psel_onehot", 64'(bad), 64'd0);
      chk("psel_seen", 64'(seen), 64'd1);
      chk("hresp_last_wait", 64'(last_resp), 64'(err_exp));
      chk("hresp_final", 64'(HRESP), 64'(err_exp));
      chk("psel_penable_drop", 64'({PSEL, PENABLE}), 64'd0);
      chk("paddr", 64'(PADDR), 64'(addr));
      chk("pwrite", 64'(PWRITE), 64'(wr));
      chk("pstrb", 64'(PSTRB), 64'(exp_strb));
      chk("pprot", 64'(PPROT), 64'({~prot[0], 1'b0, prot[1]}));
      if (wr) chk("pwdata", 64'(PWDATA), 64'(wdata));
      else if (!err_exp) chk("hrdata", 64'(HRDATA), 64'(rdv));
      if (err_exp) begin
         tick();
         chk("err_to_idle", 64'({HREADYOUT, HRESP}), 64'(2'b10));
      end
   endtask

   initial begin
      int          t, tgt, w;
      logic [2:0]  sz;
      logic [1:0]  off;
      logic [31:0] addr;

      HRESETn = 1'b0; HSEL = 1'b0; HSEL3 = 1'b0; HWRITE = 1'b0; HREADY = 1'b1; PCLKEN = 1'b1;
      HADDR = '0; HWDATA = '0; HTRANS = 2'b00; HSIZE = 3'b010; HPROT = 4'b0000;
      PRDATA = '0; PREADY = '0; PSLVERR = '0;
      repeat (3) tick();
      chk("rst_ahb", 64'({HREADYOUT, HRESP, HRDATA}), 64'({1'b1, 1'b0, 32'h0}));
      chk("rst_apb_ctl", 64'({PSEL, PENABLE, PWRITE, PSTRB, PPROT, PRESETn}), 64'd0);
      chk("rst_apb_dat", {PADDR, PWDATA}, 64'd0);
      chk("rst_dut3", 64'({h3_readyout, h3_resp, p3_sel, p3_enable}), 64'(6'b100000));
      HRESETn = 1'b1;
      tick();
      chk("presetn", 64'(PRESETn), 64'd1);
      chk("pclk_follows_pclken", 64'(PCLK), 64'(PCLKEN));

      // IDLE and BUSY transfers complete with zero wait OKAY.
      HSEL = 1'b1; HTRANS = 2'b01; HADDR = 32'h0000_2000;
      tick();
      chk("busy_okay", 64'({HREADYOUT, HRESP, PSEL}), 64'(6'b100000));
      HTRANS = 2'b00;
      tick();
      chk("idle_okay", 64'({HREADYOUT, HRESP, PSEL}), 64'(6'b100000));
      HSEL = 1'b0;

      div = 1;
      xfer(2, 1'b0, 3'b010, 32'h0000_2004, 4'b0001, 32'h0, 32'hA5A5_1234, 0, 1'b0);
      xfer(1, 1'b1, 3'b000, 32'h0000_1003, 4'b0011, 32'hDD00_0000, 32'h0, 0, 1'b0);
      xfer(1, 1'b1, 3'b001, 32'h0000_1002, 4'b0010, 32'h1234_5678, 32'h0, 0, 1'b0);

      div = 3;
      xfer(0, 1'b0, 3'b010, 32'h0000_0010, 4'b0000, 32'h0, 32'hCAFE_F00D, 2, 1'b0);

      div = 1;
      xfer(1, 1'b1, 3'b010, 32'h0000_1008, 4'b0001, 32'h5555_AAAA, 32'h0, 0, 1'b1);
      noise_err3 = 1'b1;
      xfer(1, 1'b1, 3'b010, 32'h0000_100C, 4'b0001, 32'h0BAD_0BAD, 32'h0, 0, 1'b0);
      noise_err3 = 1'b0;

      // Index 3 does not exist on the three-slave bridge.
      HSEL3 = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_3000; HWRITE = 1'b0;
      tick();
      HSEL3 = 1'b0; HTRANS = 2'b00;
      chk("miss_err1", 64'({h3_readyout, h3_resp, p3_sel}), 64'(5'b01000));
      tick();
      chk("miss_err2", 64'({h3_readyout, h3_resp, p3_sel}), 64'(5'b11000));
      tick();
      chk("miss_idle", 64'({h3_readyout, h3_resp, p3_sel}), 64'(5'b10000));

      xfer(2, 1'b1, 3'b010, 32'h0000_2020, 4'b0000, 32'h7777_0000, 32'h0, 100, 1'b0);

      // Asynchronous reset in the middle of ACCESS.
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_2010; HWRITE = 1'b0; HSIZE = 3'b010;
      drive_slaves(2, 0, 100, 1'b0);
      tick();
      HSEL = 1'b0; HTRANS = 2'b00;
      t = 0;
      while (PENABLE !== 1'b1 && t < 20) begin
         t++;
         tick();
      end
      chk("reach_access", 64'(PENABLE), 64'd1);
      #2 HRESETn = 1'b0;
      #1;
      chk("rst_async", 64'({PSEL, PENABLE, HREADYOUT, HRESP}), 64'(7'b0000010));
      tick();
      tick();
      HRESETn = 1'b1;
      tick();
      xfer(3, 1'b0, 3'b010, 32'h0000_3004, 4'b0001, 32'h0, 32'h0F0F_1E1E, 1, 1'b0);

      for (int n = 0; n < 40; n++) begin
         div = 1 + int'($urandom % 3);
         tgt = int'($urandom % 4);
         sz  = 3'($urandom % 3);
         off = 2'($urandom % 4);
         if (sz == 3'b001) off[0] = 1'b0;
         if (sz == 3'b010) off = 2'b00;
         addr = ($urandom & 32'hFFFF_CFFC) | (32'(tgt) << 12) | 32'(off);
         w = (($urandom % 8) == 0) ? 9 : int'($urandom % 4);
         xfer(tgt, 1'($urandom % 2), sz, addr, 4'($urandom), $urandom, $urandom, w,
              (($urandom % 5) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
